lb_window_ctrl: RTL and testbench

- Sequences the 5-row pixel line buffer for the Canny window stage.
- Accepts the camera capture pixel stream and frame markers, then drives the line buffer's load enable, pixel input and clear.
- Tracks row and column position and flags which buffer output columns form a valid 5x5 window, with its centre coordinates.
- Detects line-length and frame-length synchronisation errors.

---
 rtl/lb_pkg.sv | 21 ++
 rtl/lb_pos_counter.sv | 77 +++++++
 rtl/lb_window_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_lb_window_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// Shared types and constants for the 5-row line buffer window controller.
package lb_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    PRIME  = 2'd2,
    STREAM = 2'd3
  } lb_state_e;

  // Window height/width, fixed by the line buffer's five outputs
  localparam int WIN      = 5;
  // Distance from the newest window column/row to the window centre
  localparam int WIN_HALF = (WIN - 1) / 2;
  // Grey pixel width
  localparam int DATA_W   = 8;
  // Cycles from an accepted pixel to its window flag
  localparam int PIPE_LAT = 2;

endpackage

// File: rtl/lb_pos_counter.sv
// Row/column position counter for the incoming pixel stream.
// Wraps at end of line, resynchronises on an early eol and reports the
// position flags the controller needs for the pixel currently presented.
module lb_pos_counter
  import lb_pkg::*;
#(
  parameter int IMG_W = 514,
  parameter int IMG_H = 514,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic             eol_i,
  output logic [CNT_W-1:0] row_o,
  output logic [CNT_W-1:0] col_o,
  output logic             last_pix_o,
  output logic             prime_done_o,
  output logic             eol_err_o,
  output logic             win_ok_o
);

  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] ROW_PRIME = CNT_W'(WIN - 2);
  localparam logic [CNT_W-1:0] WIN_M1    = CNT_W'(WIN - 1);

  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic             last_col_s;
  logic             wrap_s;

  // Position flags and next-position arithmetic for the current pixel
  always_comb begin
    last_col_s   = (col_q == COL_LAST);
    // A row ends either at the last column or on an eol marker (resync)
    wrap_s       = last_col_s || eol_i;
    eol_err_o    = last_col_s ^ eol_i;
    last_pix_o   = last_col_s && (row_q == ROW_LAST);
    // Any row end on the last priming row moves us to streaming, so an
    // eol resync inside that row cannot leave the FSM stuck in PRIME
    prime_done_o = wrap_s && (row_q == ROW_PRIME);
    win_ok_o     = (row_q >= WIN_M1) && (col_q >= WIN_M1);
    row_d        = row_q;
    col_d        = col_q;
    if (clr_i) begin
      row_d = {CNT_W{1'b0}};
      col_d = {CNT_W{1'b0}};
    end else if (adv_i) begin
      if (wrap_s) begin
        col_d = {CNT_W{1'b0}};
        row_d = row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= {CNT_W{1'b0}};
      col_q <= {CNT_W{1'b0}};
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/lb_window_ctrl.sv
// Line buffer sequencer for the Canny 5x5 window stage: forwards the
// capture stream into the line buffer, clears it at frame start, and flags
// which buffer output columns form a valid window together with its centre.
module lb_window_ctrl
  import lb_pkg::*;
#(
  parameter int IMG_W = 514,
  parameter int IMG_H = 514,
  parameter int CNT_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sof,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              eol,
  output logic              lb_clr,
  output logic              lb_ld,
  output logic [DATA_W-1:0] lb_pixel,
  output logic              win_valid,
  output logic [CNT_W-1:0]  win_row,
  output logic [CNT_W-1:0]  win_col,
  output logic              busy,
  output logic              frame_done,
  output logic              sync_err
);

  typedef struct packed {
    logic             vld;
    logic             fd;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
  } win_pipe_t;

  lb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  row_s, col_s;
  logic              last_pix_s, prime_done_s, eol_err_s, win_ok_s;
  logic              start_s, abort_s, accept_s, cnt_clr_s, win_hit_s;
  logic              lb_clr_q, lb_clr_d;
  logic              lb_ld_q, lb_ld_d;
  logic [DATA_W-1:0] lb_pixel_q, lb_pixel_d;
  logic              busy_q, busy_d;
  logic              sync_err_q, sync_err_d;
  logic              clr_pend_q, clr_pend_d;
  win_pipe_t         pipe_q [PIPE_LAT];
  win_pipe_t         pipe_d [PIPE_LAT];

  // Decode the stream events that steer both the FSM and the datapath
  always_comb begin
    start_s   = (state_q == IDLE) && sof && en;
    // sof while busy always restarts; the pixel in the same cycle is lost
    abort_s   = (state_q != IDLE) && sof;
    accept_s  = ((state_q == PRIME) || (state_q == STREAM)) && pix_valid && !sof;
    cnt_clr_s = start_s || abort_s;
  end

  lb_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CNT_W (CNT_W)
  ) u_pos (
    .clk          (clk),
    .rst_n        (rst),
    .clr_i        (cnt_clr_s),
    .adv_i        (accept_s),
    .eol_i        (eol),
    .row_o        (row_s),
    .col_o        (col_s),
    .last_pix_o   (last_pix_s),
    .prime_done_o (prime_done_s),
    .eol_err_o    (eol_err_s),
    .win_ok_o     (win_ok_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_s) state_d = CLEAR;
        else         state_d = IDLE;
      end
      CLEAR: begin
        if (sof) state_d = CLEAR;
        else     state_d = PRIME;
      end
      PRIME: begin
        if (sof)                          state_d = CLEAR;
        else if (accept_s && last_pix_s)   state_d = IDLE;
        else if (accept_s && prime_done_s) state_d = STREAM;
        else                               state_d = PRIME;
      end
      STREAM: begin
        if (sof)                        state_d = CLEAR;
        else if (accept_s && last_pix_s) state_d = IDLE;
        else                             state_d = STREAM;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and error flag next values
  always_comb begin
    lb_clr_d   = (state_d == CLEAR);
    busy_d     = (state_d != IDLE);
    lb_ld_d    = accept_s;
    lb_pixel_d = accept_s ? pix_data : lb_pixel_q;
    sync_err_d = sync_err_q;
    clr_pend_d = 1'b0;
    case (state_q)
      IDLE: begin
        // A pixel colliding with the starting sof is lost and reported
        if (start_s) sync_err_d = pix_valid;
        else         sync_err_d = sync_err_q;
      end
      CLEAR: begin
        if (sof) begin
          sync_err_d = 1'b1;
          clr_pend_d = 1'b1;
        end else if (pix_valid) begin
          sync_err_d = 1'b1;
        end else if (clr_pend_q) begin
          // The abort error is shown for the CLEAR cycle only
          sync_err_d = 1'b0;
        end else begin
          sync_err_d = sync_err_q;
        end
      end
      PRIME, STREAM: begin
        if (sof) begin
          sync_err_d = 1'b1;
          clr_pend_d = 1'b1;
        end else if (accept_s && eol_err_s) begin
          sync_err_d = 1'b1;
        end else begin
          sync_err_d = sync_err_q;
        end
      end
      default: begin
        sync_err_d = sync_err_q;
        clr_pend_d = 1'b0;
      end
    endcase
  end

  // Window alignment pipeline, squashed when a frame is aborted
  always_comb begin
    win_hit_s = accept_s && win_ok_s && (state_q == STREAM);
    for (int i = 0; i < PIPE_LAT; i++) begin
      pipe_d[i] = '0;
    end
    pipe_d[0].vld = win_hit_s;
    pipe_d[0].fd  = accept_s && last_pix_s;
    if (win_hit_s) begin
      pipe_d[0].row = row_s - CNT_W'(WIN_HALF);
      pipe_d[0].col = col_s - CNT_W'(WIN_HALF);
    end else begin
      pipe_d[0].row = {CNT_W{1'b0}};
      pipe_d[0].col = {CNT_W{1'b0}};
    end
    for (int i = 1; i < PIPE_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    for (int i = 0; i < PIPE_LAT; i++) begin
      if (abort_s) begin
        pipe_d[i].vld = 1'b0;
        pipe_d[i].fd  = 1'b0;
      end else begin
        pipe_d[i].vld = pipe_d[i].vld;
        pipe_d[i].fd  = pipe_d[i].fd;
      end
    end
  end

  // Output and pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lb_clr_q   <= 1'b0;
      lb_ld_q    <= 1'b0;
      lb_pixel_q <= {DATA_W{1'b0}};
      busy_q     <= 1'b0;
      sync_err_q <= 1'b0;
      clr_pend_q <= 1'b0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      lb_clr_q   <= lb_clr_d;
      lb_ld_q    <= lb_ld_d;
      lb_pixel_q <= lb_pixel_d;
      busy_q     <= busy_d;
      sync_err_q <= sync_err_d;
      clr_pend_q <= clr_pend_d;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign lb_clr     = lb_clr_q;
  assign lb_ld      = lb_ld_q;
  assign lb_pixel   = lb_pixel_q;
  assign busy       = busy_q;
  assign sync_err   = sync_err_q;
  assign win_valid  = pipe_q[PIPE_LAT-1].vld;
  assign frame_done = pipe_q[PIPE_LAT-1].fd;
  assign win_row    = pipe_q[PIPE_LAT-1].row;
  assign win_col    = pipe_q[PIPE_LAT-1].col;

endmodule

// File: tb/tb_lb_window_ctrl.sv
// Self-checking bench for lb_window_ctrl on an 8x6 image.
// A cycle-indexed expectation model, filled from the stream rules as each
// input cycle is driven, is compared against the DUT on every falling edge.
module tb_lb_window_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = 10;
  localparam int N  = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          en = 1'b0, sof = 1'b0, pix_valid = 1'b0, eol = 1'b0;
  logic [7:0]    pix_data = 8'd0;
  logic          lb_clr, lb_ld, win_valid, busy, frame_done, sync_err;
  logic [7:0]    lb_pixel;
  logic [CW-1:0] win_row, win_col;

  lb_window_ctrl #(.IMG_W(W), .IMG_H(H), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .sof(sof), .pix_valid(pix_valid),
    .pix_data(pix_data), .eol(eol), .lb_clr(lb_clr), .lb_ld(lb_ld),
    .lb_pixel(lb_pixel), .win_valid(win_valid), .win_row(win_row),
    .win_col(win_col), .busy(busy), .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Expected outputs, indexed by the clock edge after which they are visible
  bit       e_clr [N];
  bit       e_ld  [N];
  bit [7:0] e_px  [N];
  bit       e_wv  [N];
  int       e_wr  [N];
  int       e_wc  [N];
  bit       e_fd  [N];
  bit       e_busy[N];
  bit       e_err [N];

  // Model state: 0 idle, 1 clearing, 2 accepting pixels
  int m_st, m_row, m_col;
  bit m_err, m_pend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      e_clr[i] = 0; e_ld[i] = 0; e_px[i] = 0; e_wv[i] = 0; e_wr[i] = 0;
      e_wc[i] = 0; e_fd[i] = 0; e_busy[i] = 0; e_err[i] = 0;
    end
    m_st = 0; m_row = 0; m_col = 0; m_err = 0; m_pend = 0;
  endtask

  // Apply the stream rules to one input cycle consumed at edge k
  task automatic model_step(input int k, input bit s, input bit e, input bit pv,
                            input logic [7:0] pd, input bit eo);
    bit clr, last;
    clr = 0;
    if (m_st == 0) begin
      if (s && e) begin
        m_st = 1; m_row = 0; m_col = 0; m_err = pv; m_pend = 0; clr = 1;
      end
    end else if (s) begin
      m_st = 1; m_row = 0; m_col = 0; m_err = 1; m_pend = 1; clr = 1;
      e_wv[k] = 0; e_fd[k] = 0;
    end else if (m_st == 1) begin
      m_st = 2;
      if (pv) m_err = 1;
      else if (m_pend) m_err = 0;
      m_pend = 0;
    end else if (pv) begin
      e_ld[k] = 1; e_px[k] = pd;
      if (m_row >= 4 && m_col >= 4) begin
        e_wv[k+1] = 1; e_wr[k+1] = m_row - 2; e_wc[k+1] = m_col - 2;
      end
      last = (m_row == H - 1) && (m_col == W - 1);
      if (last) e_fd[k+1] = 1;
      if (eo != (m_col == W - 1)) m_err = 1;
      if (eo || m_col == W - 1) begin m_col = 0; m_row++; end
      else m_col++;
      if (last) m_st = 0;
    end
    e_clr[k] = clr; e_busy[k] = (m_st != 0); e_err[k] = m_err;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("lb_clr", lb_clr, e_clr[cyc]);
      chk("lb_ld", lb_ld, e_ld[cyc]);
      if (e_ld[cyc]) chk("lb_pixel", lb_pixel, e_px[cyc]);
      chk("win_valid", win_valid, e_wv[cyc]);
      if (e_wv[cyc]) begin
        chk("win_row", win_row, e_wr[cyc]);
        chk("win_col", win_col, e_wc[cyc]);
      end
      chk("frame_done", frame_done, e_fd[cyc]);
      chk("busy", busy, e_busy[cyc]);
      chk("sync_err", sync_err, e_err[cyc]);
    end
  end

  // Event counters used by the hand-computed per-test expectations
  int c_clr, c_ld, c_wv, c_fd, c_busy, first_r, first_c, last_r, last_c;
  bit last_fd;
  always @(negedge clk) begin
    c_clr  += int'(lb_clr);
    c_ld   += int'(lb_ld);
    c_fd   += int'(frame_done);
    c_busy += int'(busy);
    if (win_valid) begin
      if (c_wv == 0) begin first_r = int'(win_row); first_c = int'(win_col); end
      last_r = int'(win_row); last_c = int'(win_col); last_fd = frame_done;
      c_wv++;
    end
  end

  task automatic mon_clear();
    c_clr = 0; c_ld = 0; c_wv = 0; c_fd = 0; c_busy = 0;
    first_r = -1; first_c = -1; last_r = -1; last_c = -1; last_fd = 0;
  endtask

  task automatic drive(input bit s, input bit e, input bit pv, input logic [7:0] pd, input bit eo);
    if (cyc + 2 >= N) begin
      n_fail++;
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, N);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1);
    end
    sof = s; en = e; pix_valid = pv; pix_data = pd; eol = eo;
    model_step(cyc + 1, s, e, pv, pd, eo);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 8'd0, 0);
  endtask

  // One frame of pixels value=col+8*row; optional early eol at (er,ec);
  // mode 1 injects sof at (sr,sc), mode 2 stops before (sr,sc)
  task automatic run_frame(input bit do_sof, input bit gap, input int er, input int ec,
                           input int mode, input int sr, input int sc);
    int r, c;
    bit eo;
    r = 0; c = 0;
    if (do_sof) drive(1, 1, 0, 8'd0, 0);
    idle(1);
    while (r < H) begin
      if (mode != 0 && r == sr && c == sc) begin
        if (mode == 1) drive(1, 1, 0, 8'd0, 0);
        return;
      end
      eo = (c == W - 1) || (r == er && c == ec);
      drive(0, 0, 1, 8'(c + 8 * r), eo);
      if (gap) idle(1);
      if (eo) begin c = 0; r++; end
      else c++;
    end
  endtask

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("reset_outputs", {lb_clr, lb_ld, lb_pixel, win_valid, win_row, win_col, frame_done, sync_err}, 0);
    chk("reset_busy", busy, 0);
    #19 rst = 1'b1;
    model_reset();
    chk_en = 1'b1;
    @(posedge clk); #1;

    // 1: clean back-to-back frame
    mon_clear();
    run_frame(1, 0, -1, -1, 0, 0, 0);
    idle(4);
    chk("t1_clr_count", c_clr, 1);
    chk("t1_ld_count", c_ld, 48);
    chk("t1_win_count", c_wv, 8);
    chk("t1_first_row", first_r, 2);
    chk("t1_first_col", first_c, 2);
    chk("t1_last_row", last_r, 3);
    chk("t1_last_col", last_c, 5);
    chk("t1_done_with_last_win", last_fd, 1);
    chk("t1_done_count", c_fd, 1);
    chk("t1_busy_end", busy, 0);

    // 2: pixels every other cycle
    mon_clear();
    run_frame(1, 1, -1, -1, 0, 0, 0);
    idle(4);
    chk("t2_ld_count", c_ld, 48);
    chk("t2_win_count", c_wv, 8);
    chk("t2_done_count", c_fd, 1);

    // 3: early eol at row 1 col 5
    mon_clear();
    run_frame(1, 0, 1, 5, 0, 0, 0);
    idle(4);
    chk("t3_ld_count", c_ld, 46);
    chk("t3_win_count", c_wv, 8);
    chk("t3_done_count", c_fd, 1);
    chk("t3_sync_err_sticky", sync_err, 1);

    // 4: sof injected at row 3 col 4, then a full frame
    mon_clear();
    run_frame(1, 0, -1, -1, 1, 3, 4);
    chk("t4_err_in_clear", sync_err, 1);
    chk("t4_clr_pulse", lb_clr, 1);
    idle(1);
    chk("t4_err_cleared", sync_err, 0);
    run_frame(0, 0, -1, -1, 0, 0, 0);
    idle(4);
    chk("t4_clr_count", c_clr, 2);
    chk("t4_win_count", c_wv, 8);
    chk("t4_done_count", c_fd, 1);

    // 5: sof ignored with en=0; sof colliding with a pixel
    mon_clear();
    drive(1, 0, 0, 8'd0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 8'(i + 1), 0);
    idle(2);
    chk("t5_no_clr", c_clr, 0);
    chk("t5_no_ld", c_ld, 0);
    chk("t5_not_busy", c_busy, 0);
    drive(1, 1, 1, 8'hAA, 0);
    chk("t5_collide_err", sync_err, 1);
    chk("t5_collide_clr", lb_clr, 1);
    chk("t5_collide_no_ld", lb_ld, 0);
    idle(2);

    // 6: asynchronous reset mid-stream, then a clean frame
    run_frame(1, 0, -1, -1, 2, 4, 6);
    chk_en = 1'b0;
    sof = 0; en = 0; pix_valid = 0; eol = 0;
    #3 rst = 1'b0;
    #1;
    chk("t6_async_reset_outputs", {lb_clr, lb_ld, lb_pixel, win_valid, win_row, win_col, frame_done, sync_err}, 0);
    chk("t6_async_reset_busy", busy, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    chk_en = 1'b1;
    @(posedge clk); #1;
    mon_clear();
    run_frame(1, 0, -1, -1, 0, 0, 0);
    idle(4);
    chk("t6_ld_count", c_ld, 48);
    chk("t6_win_count", c_wv, 8);
    chk("t6_done_count", c_fd, 1);
    chk("t6_no_err", sync_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
